// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall and exception-redirect controller.
// Ports: clk, reset (sync, active-high), stallreq_if/id/ex/mem, exc_valid,
//   exc_code, exc_epc, ebase -> stall[5:0], flush, new_pc, exc_ack,
//   epc_out, cause_code, stall_cycles.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic [31:0] ebase,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        exc_ack,
  output logic [31:0] epc_out,
  output logic [4:0]  cause_code,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;

  // Run-state stall: the oldest requesting stage freezes itself and
  // everything upstream of it.
  always_comb begin
    stall = 6'b000000;
    unique case (state)
      RUN: begin
        priority case (1'b1)
          stallreq_mem: stall = 6'b011111;
          stallreq_ex:  stall = 6'b001111;
          stallreq_id:  stall = 6'b000111;
          stallreq_if:  stall = 6'b000011;
          default:      stall = 6'b000000;
        endcase
      end
      DRAIN:   stall = 6'b011111;
      FLUSH:   stall = 6'b000000;
      default: stall = 6'b000000;
    endcase
  end

  // Moore decode: redirect signals depend on state alone.
  always_comb begin
    flush   = (state == FLUSH);
    exc_ack = (state == FLUSH);
    new_pc  = (state == FLUSH) ? (ebase + 32'h0000_0180) : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      epc_out      <= 32'h0;
      cause_code   <= 5'h0;
      stall_cycles <= 32'h0;
    end else begin
      if (stall[0] && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      unique case (state)
        RUN: begin
          if (exc_valid) begin
            epc_out    <= exc_epc;
            cause_code <= exc_code;
            // An outstanding data bus access must finish before flushing.
            state      <= stallreq_mem ? DRAIN : FLUSH;
          end
        end
        DRAIN: begin
          if (!stallreq_mem)
            state <= FLUSH;
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed rows push expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, ebase;
  logic [5:0]  stall;
  logic        flush, exc_ack;
  logic [31:0] new_pc, epc_out, stall_cycles;
  logic [4:0]  cause_code;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_epc(exc_epc), .ebase(ebase),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .exc_ack(exc_ack), .epc_out(epc_out),
    .cause_code(cause_code), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, sif, sid, sex, smem, ev;
    logic [4:0]  code;
    logic [31:0] epc, eb;
    logic [5:0]  st;
    logic        fl, ack;
    logic [31:0] npc, eo;
    logic [4:0]  co;
  } row_t;

  typedef struct {
    int          idx;
    logic [5:0]  st;
    logic        fl, ack;
    logic [31:0] npc, eo, sc;
    logic [4:0]  co;
  } exp_t;

  row_t rows[$];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] E = 32'hBFC0_0200;
  localparam logic [31:0] P = 32'hBFC0_0380;

  function automatic row_t mk(
    logic rst, logic sif, logic sid, logic sex, logic smem,
    logic ev, logic [4:0] code, logic [31:0] epc, logic [31:0] eb,
    logic [5:0] st, logic fl, logic ack, logic [31:0] npc,
    logic [31:0] eo, logic [4:0] co);
    row_t r;
    r.rst = rst; r.sif = sif; r.sid = sid; r.sex = sex;
    r.smem = smem; r.ev = ev; r.code = code; r.epc = epc;
    r.eb = eb; r.st = st; r.fl = fl; r.ack = ack;
    r.npc = npc; r.eo = eo; r.co = co;
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] got,
                     logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", nm, idx, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", e.idx, {26'h0, stall}, {26'h0, e.st});
      chk("flush_ack", e.idx, {30'h0, flush, exc_ack},
          {30'h0, e.fl, e.ack});
      chk("new_pc", e.idx, new_pc, e.npc);
      chk("epc_out", e.idx, epc_out, e.eo);
      chk("cause", e.idx, {27'h0, cause_code}, {27'h0, e.co});
      chk("stall_cycles", e.idx, stall_cycles, e.sc);
    end
  end

  initial begin
    logic [31:0] exp_sc;
    int          budget;
    // idle / stall priority
    rows.push_back(mk(0,0,0,0,0,0,0,0,E, 6'b000000,0,0,0,0,0));
    rows.push_back(mk(0,1,0,0,0,0,0,0,E, 6'b000011,0,0,0,0,0));
    rows.push_back(mk(0,0,1,0,0,0,0,0,E, 6'b000111,0,0,0,0,0));
    rows.push_back(mk(0,0,1,1,0,0,0,0,E, 6'b001111,0,0,0,0,0));
    rows.push_back(mk(0,1,0,0,1,0,0,0,E, 6'b011111,0,0,0,0,0));
    rows.push_back(mk(0,1,0,0,0,0,0,0,E, 6'b000011,0,0,0,0,0));
    // exception, no stalls
    rows.push_back(mk(0,0,0,0,0,1,5'h04,32'h8000_0010,E,
                      6'b000000,0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E,
                      6'b000000,1,1,P,32'h8000_0010,5'h04));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E,
                      6'b000000,0,0,0,32'h8000_0010,5'h04));
    // exception with IF stall, then ignored exc in FLUSH, wrap new_pc
    rows.push_back(mk(0,1,0,0,0,1,5'h0C,32'hA000_0004,E,
                      6'b000011,0,0,0,32'h8000_0010,5'h04));
    rows.push_back(mk(0,0,0,0,1,1,5'h1F,32'hDEAD_BEEF,32'hFFFF_FF00,
                      6'b000000,1,1,32'h0000_0080,32'hA000_0004,5'h0C));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E,
                      6'b000000,0,0,0,32'hA000_0004,5'h0C));
    // exception under mem stall: drain 3 more cycles
    rows.push_back(mk(0,0,0,0,1,1,5'h05,32'h8000_0100,E,
                      6'b011111,0,0,0,32'hA000_0004,5'h0C));
    rows.push_back(mk(0,0,0,0,1,1,5'h07,32'h1234_5678,E,
                      6'b011111,0,0,0,32'h8000_0100,5'h05));
    rows.push_back(mk(0,0,0,0,1,0,0,0,E,
                      6'b011111,0,0,0,32'h8000_0100,5'h05));
    rows.push_back(mk(0,1,0,0,1,0,0,0,E,
                      6'b011111,0,0,0,32'h8000_0100,5'h05));
    rows.push_back(mk(0,0,0,1,0,0,0,0,E,
                      6'b011111,0,0,0,32'h8000_0100,5'h05));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E,
                      6'b000000,1,1,P,32'h8000_0100,5'h05));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E,
                      6'b000000,0,0,0,32'h8000_0100,5'h05));
    // reset while draining
    rows.push_back(mk(0,0,0,0,1,1,5'h02,32'h0000_0044,E,
                      6'b011111,0,0,0,32'h8000_0100,5'h05));
    rows.push_back(mk(1,0,0,0,1,0,0,0,E,
                      6'b011111,0,0,0,32'h0000_0044,5'h02));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E, 6'b000000,0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E, 6'b000000,0,0,0,0,0));
    // reset while in FLUSH
    rows.push_back(mk(0,0,0,0,0,1,5'h03,32'h0000_0100,E,
                      6'b000000,0,0,0,0,0));
    rows.push_back(mk(1,0,0,0,0,0,0,0,E,
                      6'b000000,1,1,P,32'h0000_0100,5'h03));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E, 6'b000000,0,0,0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0,E, 6'b000000,0,0,0,0,0));

    reset = 1'b1;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
    exc_valid = 1'b0; exc_code = 5'h0;
    exc_epc = 32'h0; ebase = E;
    repeat (2) @(posedge clk);
    #1;
    exp_sc = 32'h0;
    for (int i = 0; i < rows.size(); i++) begin
      exp_t e;
      reset        = rows[i].rst;
      stallreq_if  = rows[i].sif;
      stallreq_id  = rows[i].sid;
      stallreq_ex  = rows[i].sex;
      stallreq_mem = rows[i].smem;
      exc_valid    = rows[i].ev;
      exc_code     = rows[i].code;
      exc_epc      = rows[i].epc;
      ebase        = rows[i].eb;
      e.idx = i; e.st = rows[i].st; e.fl = rows[i].fl;
      e.ack = rows[i].ack; e.npc = rows[i].npc;
      e.eo = rows[i].eo; e.co = rows[i].co; e.sc = exp_sc;
      q.push_back(e);
      if (rows[i].rst) exp_sc = 32'h0;
      else if (rows[i].st[0]) exp_sc = exp_sc + 32'd1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    {stallreq_id, stallreq_ex, stallreq_mem, exc_valid} = 4'b0;
    stallreq_if = 1'b0;

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    n_cmp++;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d left want 0", q.size());
    end

    // counter saturation near the top of its range
    stallreq_if = 1'b1;
    @(negedge clk);
    force dut.stall_cycles = 32'hFFFF_FFFD;
    @(negedge clk);
    release dut.stall_cycles;
    repeat (4) @(negedge clk);
    chk("sat_a", 0, stall_cycles, 32'hFFFF_FFFF);
    chk("sat_stall", 0, {26'h0, stall}, {26'h0, 6'b000011});
    repeat (3) @(negedge clk);
    chk("sat_b", 0, stall_cycles, 32'hFFFF_FFFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stallreq_if = 1'b0;
    chk("sat_reset", 0, stall_cycles, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have clk  input  1  pipeline clock, all state updated on rising edge.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have stallreq_if  input  1  fetch stage waiting on instruction bus.
REQ-004 SHALL have stallreq_id  input  1  decode load-use hazard.
REQ-005 SHALL have stallreq_ex  input  1  multi-cycle mult/div busy.
REQ-006 SHALL have stallreq_mem  input  1  data bus transaction outstanding.
REQ-007 SHALL have exc_valid  input  1  exception raised by MEM stage this cycle.
REQ-008 SHALL have exc_code  input  5  exception cause code.
REQ-009 SHALL have exc_epc  input  32  faulting instruction address.
REQ-010 SHALL have ebase  input  32  exception base address.
REQ-011 SHALL have stall  output  6  per-stage stop vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop.
REQ-012 SHALL have flush  output  1  clear all pipeline registers.
REQ-013 SHALL have new_pc  output  32  redirect target, valid when flush=1.
REQ-014 SHALL have exc_ack  output  1  one-cycle exception accepted pulse.
REQ-015 SHALL have epc_out  output  32  captured EPC.
REQ-016 SHALL have cause_code  output  5  captured cause.
REQ-017 SHALL have stall_cycles  output  32  PC-stall cycle counter.

Function
REQ-018 SHALL implement FSM states RUN, DRAIN, FLUSH; flush, exc_ack, new_pc decoded from state only (Moore).
REQ-019 In RUN, stall SHALL be combinational, priority mem > ex > id > if: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-020 In RUN with exc_valid=1 and stallreq_mem=0: capture exc_epc→epc_out, exc_code→cause_code; next state FLUSH.
REQ-021 In RUN with exc_valid=1 and stallreq_mem=1: capture epc/code same cycle; next state DRAIN.
REQ-022 In DRAIN, stall SHALL be 6'b011111 regardless of other requests; remain while stallreq_mem=1; go FLUSH in cycle after stallreq_mem samples 0.
REQ-023 In FLUSH (exactly one cycle): flush=1, exc_ack=1, stall=6'b000000, new_pc=ebase+32'h180 (mod 2^32); next state RUN.
REQ-024 Outside FLUSH: flush=0, exc_ack=0, new_pc=0.
REQ-025 exc_valid SHALL be ignored in DRAIN and FLUSH; no capture, no queuing.
REQ-026 Latency: exc_valid sampled at edge N with no mem stall → flush high in cycle N+1.
REQ-027 epc_out/cause_code SHALL hold until next capture.
REQ-028 stall_cycles SHALL increment by 1 each cycle stall[0]=1, saturating at 32'hFFFFFFFF.

Reset
REQ-029 On reset: state RUN, epc_out=0, cause_code=0, stall_cycles=0; flush=0, exc_ack=0, new_pc=0 next cycle.
REQ-030 Reset in DRAIN or FLUSH SHALL abandon the pending exception; no exc_ack afterwards.

Verification
REQ-031 stallreq_if=1, stallreq_mem=1 same cycle → stall=6'b011111; drop mem → 6'b000011.
REQ-032 exc_valid=1, exc_epc=32'h8000_0010, code=5'h04, ebase=32'hBFC0_0200, no stalls → next cycle flush=1, exc_ack=1, new_pc=32'hBFC0_0380, epc_out=32'h8000_0010, then RUN.
REQ-033 exc_valid with stallreq_mem held 3 more cycles → stall=6'b011111 for those cycles, flush one cycle after mem drops, single exc_ack.
REQ-034 Second exc_valid during DRAIN with different epc → epc_out keeps first value.
REQ-035 stall_cycles preset near max via 2^32 stall cycles (or forced) → holds 32'hFFFFFFFF.
REQ-036 Reset asserted in DRAIN → RUN, all outputs zero, no flush afterwards.
